// File: rtl/core_pkg.sv
// =============================================================================
// Module      : core_pkg
// Description : Shared store-data-queue sizing and entry record type.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package core_pkg;

    localparam int SDQ_ENTRIES = 8;
    localparam int SDQ_IDX_W   = $clog2(SDQ_ENTRIES);
    localparam int SDQ_PTR_W   = SDQ_IDX_W + 1;

    localparam logic [1:0] c_size_byte = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_word = 2'd2;

    typedef struct packed {
        logic        vld;
        logic        addr_vld;
        logic        committed;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } sdq_entry_t;

endpackage

`default_nettype wire

// File: rtl/store_align.sv
// =============================================================================
// Module      : store_align
// Description : Byte-lane enables and data placement for a store write.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module store_align
    import core_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data_in,
    output logic [3:0]  be,
    output logic [31:0] data_out
);

    always_comb begin
        be = 4'b1111;
        case (size)
            c_size_byte: be = 4'b0001 << addr_lo;
            c_size_half: be = 4'b0011 << addr_lo;
            default:     be = 4'b1111;
        endcase
    end

    assign data_out = data_in << {addr_lo, 3'b000};

endmodule

`default_nettype wire

// File: rtl/store_data_queue.sv
// =============================================================================
// Module      : store_data_queue
// Description : In-order store queue with dispatch/execute/commit/drain stages.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module store_data_queue
    import core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_vld,
    output logic                 disp_full,
    output logic [SDQ_IDX_W-1:0] disp_sdq_idx,
    output logic [SDQ_PTR_W-1:0] disp_sdq_marker,
    input  logic                 exec_vld,
    input  logic [SDQ_IDX_W-1:0] exec_sdq_idx,
    input  logic [31:0]          exec_addr,
    input  logic [31:0]          exec_data,
    input  logic [1:0]           exec_size,
    input  logic                 commit_vld,
    input  logic                 flush,
    output logic                 drain_vld,
    input  logic                 drain_rdy,
    output logic [31:0]          drain_addr,
    output logic [31:0]          drain_data,
    output logic [3:0]           drain_be,
    output logic [SDQ_PTR_W-1:0] sdq_head_marker
);

    sdq_entry_t           r_ent [SDQ_ENTRIES];
    logic [SDQ_PTR_W-1:0] r_head;
    logic [SDQ_PTR_W-1:0] r_cmt;
    logic [SDQ_PTR_W-1:0] r_tail;

    logic [SDQ_PTR_W-1:0] w_occ;
    logic [SDQ_PTR_W-1:0] w_cmt_next;
    logic [SDQ_PTR_W-1:0] w_flush_cnt;
    logic [SDQ_IDX_W-1:0] w_head_idx;
    logic [SDQ_IDX_W-1:0] w_cmt_idx;
    logic [SDQ_IDX_W-1:0] w_tail_idx;
    logic                 w_disp_fire;
    logic                 w_exec_fire;
    logic                 w_commit_fire;
    logic                 w_drain_fire;
    logic [SDQ_ENTRIES-1:0] w_flush_kill;
    sdq_entry_t           w_head_ent;

    assign w_head_idx = r_head[SDQ_IDX_W-1:0];
    assign w_cmt_idx  = r_cmt[SDQ_IDX_W-1:0];
    assign w_tail_idx = r_tail[SDQ_IDX_W-1:0];
    assign w_head_ent = r_ent[w_head_idx];

    assign w_occ     = r_tail - r_head;
    assign disp_full = (w_occ == SDQ_PTR_W'(SDQ_ENTRIES));

    assign disp_sdq_idx    = w_tail_idx;
    assign disp_sdq_marker = r_tail;
    assign sdq_head_marker = r_head;

    assign w_disp_fire = disp_vld && !disp_full && !flush;
    // Committed entries are frozen so a stalled drain keeps its outputs stable.
    assign w_exec_fire = exec_vld && !flush && r_ent[exec_sdq_idx].vld
                         && !r_ent[exec_sdq_idx].committed;
    assign w_commit_fire = commit_vld && (r_cmt != r_tail) && r_ent[w_cmt_idx].addr_vld;
    assign w_cmt_next    = w_commit_fire ? r_cmt + 1'b1 : r_cmt;
    assign w_flush_cnt   = r_tail - w_cmt_next;

    // An entry is squashed when its offset from the post-commit pointer lies inside the uncommitted span.
    always_comb begin
        w_flush_kill = '0;
        for (int i = 0; i < SDQ_ENTRIES; i++) begin
            w_flush_kill[i] = ({1'b0, SDQ_IDX_W'(i) - w_cmt_next[SDQ_IDX_W-1:0]} < w_flush_cnt);
        end
    end

    assign drain_vld    = w_head_ent.vld && w_head_ent.committed && w_head_ent.addr_vld;
    assign w_drain_fire = drain_vld && drain_rdy;
    assign drain_addr   = {w_head_ent.addr[31:2], 2'b00};

    store_align u_align (
        .addr_lo  (w_head_ent.addr[1:0]),
        .size     (w_head_ent.size),
        .data_in  (w_head_ent.data),
        .be       (drain_be),
        .data_out (drain_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
            for (int i = 0; i < SDQ_ENTRIES; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            if (w_drain_fire) begin
                r_head <= r_head + 1'b1;
            end
            r_cmt <= w_cmt_next;
            if (flush) begin
                r_tail <= w_cmt_next;
            end else if (w_disp_fire) begin
                r_tail <= r_tail + 1'b1;
            end

            for (int i = 0; i < SDQ_ENTRIES; i++) begin
                if (w_drain_fire && (w_head_idx == SDQ_IDX_W'(i))) begin
                    r_ent[i].vld <= 1'b0;
                end
                if (w_disp_fire && (w_tail_idx == SDQ_IDX_W'(i))) begin
                    r_ent[i].vld       <= 1'b1;
                    r_ent[i].addr_vld  <= 1'b0;
                    r_ent[i].committed <= 1'b0;
                end
                if (w_exec_fire && (exec_sdq_idx == SDQ_IDX_W'(i))) begin
                    r_ent[i].addr     <= exec_addr;
                    r_ent[i].data     <= exec_data;
                    r_ent[i].size     <= exec_size;
                    r_ent[i].addr_vld <= 1'b1;
                end
                if (w_commit_fire && (w_cmt_idx == SDQ_IDX_W'(i))) begin
                    r_ent[i].committed <= 1'b1;
                end
                if (flush && w_flush_kill[i]) begin
                    r_ent[i].vld       <= 1'b0;
                    r_ent[i].addr_vld  <= 1'b0;
                    r_ent[i].committed <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_data_queue.sv
// =============================================================================
// Module      : tb_store_data_queue
// Description : Scoreboard bench for store_data_queue with directed vectors.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_store_data_queue;
    import core_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 disp_vld;
    logic                 disp_full;
    logic [SDQ_IDX_W-1:0] disp_sdq_idx;
    logic [SDQ_PTR_W-1:0] disp_sdq_marker;
    logic                 exec_vld;
    logic [SDQ_IDX_W-1:0] exec_sdq_idx;
    logic [31:0]          exec_addr;
    logic [31:0]          exec_data;
    logic [1:0]           exec_size;
    logic                 commit_vld;
    logic                 flush;
    logic                 drain_vld;
    logic                 drain_rdy;
    logic [31:0]          drain_addr;
    logic [31:0]          drain_data;
    logic [3:0]           drain_be;
    logic [SDQ_PTR_W-1:0] sdq_head_marker;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } drain_t;

    drain_t exp_q[$];
    int     errors = 0;
    int     checks = 0;

    store_data_queue dut (
        .clk             (clk),
        .rst             (rst),
        .disp_vld        (disp_vld),
        .disp_full       (disp_full),
        .disp_sdq_idx    (disp_sdq_idx),
        .disp_sdq_marker (disp_sdq_marker),
        .exec_vld        (exec_vld),
        .exec_sdq_idx    (exec_sdq_idx),
        .exec_addr       (exec_addr),
        .exec_data       (exec_data),
        .exec_size       (exec_size),
        .commit_vld      (commit_vld),
        .flush           (flush),
        .drain_vld       (drain_vld),
        .drain_rdy       (drain_rdy),
        .drain_addr      (drain_addr),
        .drain_data      (drain_data),
        .drain_be        (drain_be),
        .sdq_head_marker (sdq_head_marker)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted drain must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && drain_vld && drain_rdy) begin
            drain_t exp;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL drain_unexpected: got addr=%h data=%h be=%b, required none",
                         drain_addr, drain_data, drain_be);
            end else begin
                exp = exp_q.pop_front();
                if (drain_addr !== exp.addr || drain_data !== exp.data || drain_be !== exp.be) begin
                    errors++;
                    $display("FAIL drain_write: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                             drain_addr, drain_data, drain_be, exp.addr, exp.data, exp.be);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic dispatch();
        disp_vld = 1'b1;
        tick();
        disp_vld = 1'b0;
    endtask

    task automatic execute(input logic [2:0] idx, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s);
        exec_vld     = 1'b1;
        exec_sdq_idx = idx;
        exec_addr    = a;
        exec_data    = d;
        exec_size    = s;
        tick();
        exec_vld = 1'b0;
    endtask

    task automatic commit();
        commit_vld = 1'b1;
        tick();
        commit_vld = 1'b0;
    endtask

    task automatic drain_one();
        drain_rdy = 1'b1;
        tick();
        drain_rdy = 1'b0;
    endtask

    initial begin
        logic [31:0] h_addr, h_data;
        logic [3:0]  h_be;
        logic [3:0]  exp_ptr;

        rst = 1'b1; disp_vld = 1'b0; exec_vld = 1'b0; exec_sdq_idx = '0;
        exec_addr = '0; exec_data = '0; exec_size = '0;
        commit_vld = 1'b0; flush = 1'b0; drain_rdy = 1'b0;
        do_reset();

        chk("rst_full", 32'(disp_full), 32'h0);
        chk("rst_drain_vld", 32'(drain_vld), 32'h0);
        chk("rst_idx", 32'(disp_sdq_idx), 32'h0);
        chk("rst_marker", 32'(disp_sdq_marker), 32'h0);
        chk("rst_head", 32'(sdq_head_marker), 32'h0);

        // First dispatch: index visible in the same cycle, marker advances after
        disp_vld = 1'b1;
        chk("disp_idx0", 32'(disp_sdq_idx), 32'h0);
        tick();
        disp_vld = 1'b0;
        chk("marker_after_disp", 32'(disp_sdq_marker), 32'h1);
        chk("no_drain_uncommitted", 32'(drain_vld), 32'h0);

        // Byte store at offset 2
        execute(3'd0, 32'h0000_1002, 32'h0000_00AB, 2'd0);
        exp_q.push_back('{addr: 32'h0000_1000, data: 32'h00AB_0000, be: 4'b0100});
        commit();
        chk("byte_drain_vld", 32'(drain_vld), 32'h1);
        drain_one();
        chk("head_after_drain", 32'(sdq_head_marker), 32'h1);

        // Stalled drain holds outputs and head
        dispatch();
        execute(3'd1, 32'h0000_2000, 32'h1122_3344, 2'd2);
        exp_q.push_back('{addr: 32'h0000_2000, data: 32'h1122_3344, be: 4'b1111});
        commit();
        dispatch();
        h_addr = drain_addr; h_data = drain_data; h_be = drain_be;
        commit();  // entry 2 not executed: ignored
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_vld", 32'(drain_vld), 32'h1);
            chk("stall_addr", drain_addr, h_addr);
            chk("stall_data", drain_data, h_data);
            chk("stall_be", 32'(drain_be), 32'(h_be));
            chk("stall_head", 32'(sdq_head_marker), 32'h1);
        end
        drain_one();
        execute(3'd2, 32'h0000_3001, 32'h0000_BEEF, 2'd1);
        chk("commit_unexec_ignored", 32'(drain_vld), 32'h0);
        exp_q.push_back('{addr: 32'h0000_3000, data: 32'h00BE_EF00, be: 4'b0110});
        commit();
        chk("half_drain_vld", 32'(drain_vld), 32'h1);
        drain_one();
        chk("head_after_three", 32'(sdq_head_marker), 32'h3);

        // Full queue
        do_reset();
        for (int k = 0; k < 8; k++) dispatch();
        chk("full_set", 32'(disp_full), 32'h1);
        chk("full_marker", 32'(disp_sdq_marker), 32'h8);
        dispatch();
        chk("ninth_ignored", 32'(disp_sdq_marker), 32'h8);
        execute(3'd0, 32'h0000_0040, 32'hCAFE_0000, 2'd2);
        exp_q.push_back('{addr: 32'h0000_0040, data: 32'hCAFE_0000, be: 4'b1111});
        commit();
        disp_vld = 1'b1; drain_rdy = 1'b1;
        tick();
        disp_vld = 1'b0; drain_rdy = 1'b0;
        chk("same_cycle_no_room", 32'(disp_sdq_marker), 32'h8);
        chk("full_cleared", 32'(disp_full), 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_tail_to_cmt", 32'(disp_sdq_marker), 32'h1);
        chk("flush_drain_idle", 32'(drain_vld), 32'h0);

        // Flush with one committed entry of three
        dispatch(); dispatch(); dispatch();
        execute(3'd1, 32'h0000_0103, 32'h0000_005A, 2'd0);
        execute(3'd2, 32'h0000_0200, 32'h1234_5678, 2'd2);
        exp_q.push_back('{addr: 32'h0000_0100, data: 32'h5A00_0000, be: 4'b1000});
        commit();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_marker", 32'(disp_sdq_marker), 32'h2);
        chk("flush_keeps_committed", 32'(drain_vld), 32'h1);
        drain_one();
        execute(3'd2, 32'h0000_0300, 32'hDEAD_BEEF, 2'd2);
        commit();
        chk("flushed_entry_dead", 32'(drain_vld), 32'h0);
        chk("head_after_flush_drain", 32'(sdq_head_marker), 32'h2);

        // Twenty stores in order through pointer wrap
        do_reset();
        exp_ptr = 4'd0;
        for (int k = 0; k < 20; k++) begin
            chk("wrap_marker", 32'(disp_sdq_marker), 32'(exp_ptr));
            dispatch();
            execute(exp_ptr[2:0], 32'h0000_8000 + 32'(4 * k), 32'h0000_1000 + 32'(k), 2'd2);
            exp_q.push_back('{addr: 32'h0000_8000 + 32'(4 * k), data: 32'h0000_1000 + 32'(k), be: 4'b1111});
            commit();
            drain_one();
            exp_ptr = exp_ptr + 4'd1;
        end
        chk("wrap_head", 32'(sdq_head_marker), 32'h4);

        // Reset during a pending drain
        dispatch();
        execute(3'd4, 32'h0000_9000, 32'h0000_0001, 2'd2);
        commit();
        chk("pre_rst_vld", 32'(drain_vld), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_drops_drain", 32'(drain_vld), 32'h0);
        chk("rst_drops_head", 32'(sdq_head_marker), 32'h0);

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
